rr_lzc_arbiter: RTL and testbench
=================================

RR_LZC_ARBITER -- requirements
Module: rr_lzc_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (legal range 2..64).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, payload width per requester.
REQ-003 SHALL have derived parameter IDX_WIDTH = $clog2(NUM_REQ), which SHALL NOT be overridden.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all state on rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port flush_i, input, 1 bit, synchronous clear of output stage and pointer.
REQ-007 SHALL have port req_i, input, NUM_REQ bits, per-requester request.
REQ-008 SHALL have port data_i, input, NUM_REQ x DATA_WIDTH, per-requester payload.
REQ-009 SHALL have port gnt_o, output, NUM_REQ bits, one-hot-or-zero grant (combinational).
REQ-010 SHALL have port valid_o, output, 1 bit, output stage holds an entry.
REQ-011 SHALL have port ready_i, input, 1 bit, downstream accepts the entry.
REQ-012 SHALL have port data_o, output, DATA_WIDTH bits, registered winning payload.
REQ-013 SHALL have port idx_o, output, IDX_WIDTH bits, registered winning requester index.

Function
REQ-014 SHALL hold state: one output entry (valid, data, idx) and round-robin pointer ptr (IDX_WIDTH bits).
REQ-015 SHALL define two states: EMPTY (valid_o=0) and FULL (valid_o=1).
REQ-016 SHALL define accept = ~valid_o | ready_i (slot free or draining this cycle), gated by ~flush_i.
REQ-017 SHALL find the winner by a trailing-zero search on masked = req_i & (bits at index >= ptr); if masked is zero, it SHALL search on req_i unmasked.
REQ-018 SHALL assert gnt_o[winner] in the same cycle only when accept=1 and |req_i=1; gnt_o SHALL be all zero otherwise.
REQ-019 SHALL treat req_i[i] & gnt_o[i] as a requester handshake; requesters hold req/data until granted and may drop req without grant.
REQ-020 SHALL, on grant, register data_i[winner] into data_o and winner into idx_o, and set valid_o=1 next cycle (latency 1).
REQ-021 SHALL, on grant, set ptr to winner+1, wrapping to 0 when winner=NUM_REQ-1 (including non-power-of-2 NUM_REQ).
REQ-022 SHALL, for FULL with ready_i=1 and no grant, go to EMPTY; for FULL with ready_i=1 and a grant, stay FULL with the new entry (throughput 1 per cycle).
REQ-023 SHALL, for FULL with ready_i=0, keep data_o, idx_o, valid_o and ptr stable and keep gnt_o=0.
REQ-024 SHALL, on flush_i=1, next cycle force valid_o=0 and ptr=0 and issue no grant; flush SHALL win over simultaneous ready_i and req_i, dropping the held entry.
REQ-025 SHALL leave ptr unchanged in cycles with no grant.
REQ-026 SHALL keep data_o and idx_o stable while EMPTY; their value is don't-care.

Reset
REQ-027 SHALL, on rst_i=1, asynchronously set valid_o=0, ptr=0, data_o=0 and idx_o=0, and keep gnt_o=0 while reset is asserted.
REQ-028 SHALL discard any held entry when reset is asserted mid-transfer; after release the first grant starts from ptr=0.

Verification (NUM_REQ=4, DATA_WIDTH=8)
REQ-029 SHALL cover this case: reset, req_i=4'b1111, data_i[i]=0x10+i, ready_i=1 for 5 cycles -> gnt_o 0001,0010,0100,1000,0001; idx_o 0,1,2,3,0 one cycle later; data_o 0x10..0x13,0x10.
REQ-030 SHALL cover this case: ptr=2, req_i=4'b0011 -> masked empty, wrap to unmasked; gnt_o=0001, then ptr=1.
REQ-031 SHALL cover this case: FULL, ready_i=0 for 3 cycles, req_i=1111 -> gnt_o=0 and data_o/idx_o/ptr stable; ready_i=1 -> next grant in the same cycle as the drain.
REQ-032 SHALL cover this case: only req_i[3] asserted, ready_i=1 continuously -> granted every cycle, ptr toggles 0 to 0 via wrap, valid_o stays 1.
REQ-033 SHALL cover this case: FULL with idx_o=1, flush_i=1 with ready_i=1 and req_i=1111 -> gnt_o=0, next cycle valid_o=0, ptr=0; next grant goes to requester 0.
REQ-034 SHALL cover this case: rst_i pulsed mid-cycle while FULL -> valid_o falls immediately without a clock edge; NUM_REQ=3 run of req_i=111 -> idx sequence 0,1,2,0.

Source files
------------

// File: rtl/rr_lzc_arbiter.sv
// Round-robin arbiter: trailing-zero winner search over a pointer-masked request
// vector, feeding a single registered output slot with valid/ready handshake.
module rr_lzc_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]                 gnt_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [DATA_WIDTH-1:0]              data_o,
  output logic [IDX_WIDTH-1:0]               idx_o
);

  typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_WIDTH-1:0]  r_ptr;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic [DATA_WIDTH-1:0] r_data;
  logic [IDX_WIDTH-1:0]  w_winner;
  logic [IDX_WIDTH-1:0]  w_ptr_nxt;
  logic [NUM_REQ-1:0]    w_mask;
  logic [NUM_REQ-1:0]    w_masked;
  logic                  w_accept;
  logic                  w_grant;

  // Lowest set bit wins; scanning downward lets the last hit be the lowest index.
  function automatic logic [IDX_WIDTH-1:0] tz_index(input logic [NUM_REQ-1:0] vec);
    logic [IDX_WIDTH-1:0] idx;
    idx = {IDX_WIDTH{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_WIDTH'(i) : idx;
    end
    return idx;
  endfunction

  assign valid_o = (r_state == ST_FULL);
  assign data_o  = r_data;
  assign idx_o   = r_idx;

  // Pointer mask: keep requesters at or above the round-robin pointer.
  always_comb begin
    w_mask = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      w_mask[i] = (IDX_WIDTH'(i) >= r_ptr);
    end
    w_masked = req_i & w_mask;
  end

  // Winner selection and combinational grant; reset forces the grant low.
  always_comb begin
    w_winner  = (|w_masked) ? tz_index(w_masked) : tz_index(req_i);
    w_accept  = (~valid_o | ready_i) & ~flush_i;
    w_grant   = w_accept & (|req_i) & ~rst_i;
    w_ptr_nxt = (w_winner == IDX_WIDTH'(NUM_REQ - 1)) ? {IDX_WIDTH{1'b0}}
                                                       : w_winner + IDX_WIDTH'(1);
    gnt_o     = {NUM_REQ{1'b0}};
    if (w_grant) begin
      gnt_o[w_winner] = 1'b1;
    end else begin
      gnt_o = {NUM_REQ{1'b0}};
    end
  end

  // Output slot next-state: flush empties, a grant refills, a drain alone empties.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: w_state_nxt = w_grant ? ST_FULL : ST_EMPTY;
      ST_FULL: begin
        if (flush_i) begin
          w_state_nxt = ST_EMPTY;
        end else if (ready_i) begin
          w_state_nxt = w_grant ? ST_FULL : ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload, index and pointer; these hold whenever no grant is issued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr  <= {IDX_WIDTH{1'b0}};
      r_data <= {DATA_WIDTH{1'b0}};
      r_idx  <= {IDX_WIDTH{1'b0}};
    end else if (flush_i) begin
      r_ptr  <= {IDX_WIDTH{1'b0}};
    end else if (w_grant) begin
      r_ptr  <= w_ptr_nxt;
      r_data <= data_i[w_winner];
      r_idx  <= w_winner;
    end
  end

endmodule

// File: tb/tb_rr_lzc_arbiter.sv
// Bench for rr_lzc_arbiter: a 4-requester and a 3-requester instance run side by side
// against a round-robin reference model, with directed scenarios then random traffic.
module tb_rr_lzc_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             ready = 1'b0;
  logic [3:0]       req4 = 4'h0;
  logic [3:0][7:0]  data4 = 32'h0;
  logic [3:0]       gnt4;
  logic             valid4;
  logic [7:0]       dout4;
  logic [1:0]       idx4;
  logic [2:0]       req3 = 3'h0;
  logic [2:0][7:0]  data3 = 24'h0;
  logic [2:0]       gnt3;
  logic             valid3;
  logic [7:0]       dout3;
  logic [1:0]       idx3;

  int n_checks = 0;
  int n_errors = 0;

  int         m_valid [2];
  int         m_ptr   [2];
  int         m_idx   [2];
  logic [7:0] m_data  [2];

  always #5 clk = ~clk;

  rr_lzc_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_i(req4), .data_i(data4),
    .gnt_o(gnt4), .valid_o(valid4), .ready_i(ready), .data_o(dout4), .idx_o(idx4)
  );

  rr_lzc_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_i(req3), .data_i(data3),
    .gnt_o(gnt3), .valid_o(valid3), .ready_i(ready), .data_o(dout3), .idx_o(idx3)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requesting index when walking upward from ptr, wrapping.
  function automatic int rr_pick(input int req, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      int c;
      c = (ptr + k) % n;
      if (((req >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0;
      m_ptr[k]   = 0;
      m_idx[k]   = 0;
      m_data[k]  = 8'h00;
    end
  endtask

  // One cycle: called at the negedge with inputs applied; returns at the next negedge.
  task automatic step();
    int w [2];
    int n;
    int r;
    #1;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 4 : 3;
      r = (k == 0) ? int'(req4) : int'(req3);
      w[k] = (((m_valid[k] == 0) || ready) && !flush) ? rr_pick(r, m_ptr[k], n) : -1;
    end
    chk("gnt4", 32'(gnt4), (w[0] >= 0) ? (32'd1 << w[0]) : 32'd0);
    chk("gnt3", 32'(gnt3), (w[1] >= 0) ? (32'd1 << w[1]) : 32'd0);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 4 : 3;
      if (flush) begin
        m_valid[k] = 0;
        m_ptr[k]   = 0;
      end else if (w[k] >= 0) begin
        m_valid[k] = 1;
        m_idx[k]   = w[k];
        m_data[k]  = (k == 0) ? data4[w[k]] : data3[w[k]];
        m_ptr[k]   = (w[k] + 1) % n;
      end else if (ready) begin
        m_valid[k] = 0;
      end
    end
    @(negedge clk);
    chk("valid4", 32'(valid4), 32'(m_valid[0]));
    chk("valid3", 32'(valid3), 32'(m_valid[1]));
    if (m_valid[0] != 0) begin
      chk("data4", 32'(dout4), 32'(m_data[0]));
      chk("idx4", 32'(idx4), 32'(m_idx[0]));
    end
    if (m_valid[1] != 0) begin
      chk("data3", 32'(dout3), 32'(m_data[1]));
      chk("idx3", 32'(idx3), 32'(m_idx[1]));
    end
  endtask

  initial begin
    logic [3:0] exp_g [5];
    logic [1:0] hold_idx;
    logic [7:0] hold_data;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

    // Reset values, with requests present during reset
    req4 = 4'hF; req3 = 3'h7; ready = 1'b1;
    #2;
    chk("rst_gnt4", 32'(gnt4), 32'd0);
    chk("rst_gnt3", 32'(gnt3), 32'd0);
    chk("rst_valid4", 32'(valid4), 32'd0);
    chk("rst_data4", 32'(dout4), 32'd0);
    chk("rst_idx4", 32'(idx4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    req3 = 3'h0;

    // Full rotation with all requesting
    for (int i = 0; i < 4; i++) data4[i] = 8'(8'h10 + i);
    req4 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1 chk("rot_gnt", 32'(gnt4), 32'(exp_g[i]));
      step();
      chk("rot_idx", 32'(idx4), 32'(i % 4));
      chk("rot_data", 32'(dout4), 32'(8'h10 + (i % 4)));
    end

    // Masked search empty at ptr=2, wrap to unmasked
    req4 = 4'b0010;
    step();
    req4 = 4'b0011;
    #1 chk("wrap_gnt", 32'(gnt4), 32'h1);
    step();
    #1 chk("wrap_ptr1_gnt", 32'(gnt4), 32'h2);
    step();

    // Backpressure: FULL held stable, grant resumes in the drain cycle
    req4 = 4'hF; ready = 1'b0;
    hold_idx = idx4; hold_data = dout4;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_gnt", 32'(gnt4), 32'h0);
      step();
      chk("stall_idx", 32'(idx4), 32'(hold_idx));
      chk("stall_data", 32'(dout4), 32'(hold_data));
    end
    ready = 1'b1;
    #1 chk("drain_gnt", 32'(gnt4), 32'h4);
    step();

    // Single requester 3 granted every cycle
    req4 = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      #1 chk("solo_gnt", 32'(gnt4), 32'h8);
      step();
      chk("solo_valid", 32'(valid4), 32'h1);
    end

    // Flush beats ready and requests while holding idx 1
    flush = 1'b1;
    step();
    flush = 1'b0; req4 = 4'b0010;
    step();
    chk("pre_flush_idx", 32'(idx4), 32'h1);
    flush = 1'b1; req4 = 4'hF;
    #1 chk("flush_gnt", 32'(gnt4), 32'h0);
    step();
    chk("flush_valid", 32'(valid4), 32'h0);
    flush = 1'b0;
    #1 chk("post_flush_gnt", 32'(gnt4), 32'h1);
    step();

    // Three-requester rotation after flush
    flush = 1'b1;
    step();
    flush = 1'b0; req3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("n3_idx", 32'(idx3), 32'(i % 3));
    end

    // Asynchronous reset while FULL
    req4 = 4'h0; req3 = 3'h0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid4", 32'(valid4), 32'h0);
    chk("arst_valid3", 32'(valid3), 32'h0);
    chk("arst_idx4", 32'(idx4), 32'h0);
    #1 rst = 1'b0;
    reset_model();
    @(negedge clk);
    req4 = 4'hF;
    #1 chk("arst_first_gnt", 32'(gnt4), 32'h1);
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req4  = 4'($urandom);
      req3  = 3'($urandom);
      data4 = $urandom;
      data3 = 24'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
